hdbn_encoder: RTL and testbench

Parametrised HDBn line encoder for the HDB3 transmit path. It takes a unipolar NRZ bit stream, one bit per valid beat, and emits the bipolar P/N rail pair. Zero-run substitution (000V / B00V generalised to N), B insertion and alternate-mark polarity are all handled inside, so no separate polarity stage is needed. A runtime AMI mode bypasses substitution.

---
 rtl/hdbn_encoder.sv | 169 ++++++++++++++++
 tb/tb_hdbn_encoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hdbn_encoder.sv
// hdbn_encoder: HDBn line encoder (HDB3 when N = 3) for the transmit path.
//
// Takes a unipolar NRZ stream, one bit per accepted beat, and produces the bipolar
// P/N rail pair. Zero-run substitution (000V / B00V generalised to N), B insertion
// and alternate-mark polarity are all done here. A runtime AMI mode bypasses
// substitution.
//
// Parameters:
//   N          maximum zeros allowed on the line (2..7); a run of N+1 zeros is substituted
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   data_in/ami are accepted this cycle
//   data_in    NRZ bit, 1 = mark
//   ami        1 = plain AMI, no substitution (sampled with each accepted bit)
//   out_valid  one-cycle pulse, P/N carry a new symbol
//   data_outP  1 = +1 pulse
//   data_outN  1 = -1 pulse
//   viol_cnt   saturating count of V insertions (only when HDBN_STATS_EN is defined)
//
// Build option: define HDBN_STATS_EN to add the viol_cnt port and counter.

module hdbn_encoder #(
    parameter int unsigned N = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        data_in,
    input  logic        ami,
`ifdef HDBN_STATS_EN
    output logic [15:0] viol_cnt,
`endif
    output logic        out_valid,
    output logic        data_outP,
    output logic        data_outN
);

    // Internal symbol codes
    localparam logic [1:0] SymZero = 2'b00;
    localparam logic [1:0] SymMark = 2'b01;
    localparam logic [1:0] SymB    = 2'b10;
    localparam logic [1:0] SymV    = 2'b11;

    localparam logic [2:0] ZrunMax = 3'(N);
    localparam logic [3:0] FillMax = 4'(N + 1);

    logic [N:0][1:0] win_q, win_d;
    logic [2:0]      zrun_q, zrun_d;
    logic [3:0]      fill_q, fill_d;
    logic            par_q, par_d;
    logic            last_q, last_d;
    logic            p_q, p_d;
    logic            n_q, n_d;
    logic            valid_q, valid_d;
    logic [1:0]      leave;
    logic            sub;

    assign leave = win_q[N];

    // The (N+1)th consecutive zero in non-AMI mode becomes V.
    assign sub = in_valid && !data_in && !ami && (zrun_q == ZrunMax);

    always_comb begin
        win_d   = win_q;
        zrun_d  = zrun_q;
        fill_d  = fill_q;
        par_d   = par_q;
        last_d  = last_q;
        p_d     = p_q;
        n_d     = n_q;
        valid_d = 1'b0;

        if (in_valid) begin
            for (int unsigned i = 1; i <= N; i++) begin
                win_d[i] = win_q[i-1];
            end

            if (data_in) begin
                win_d[0] = SymMark;
                zrun_d   = 3'd0;
                if (!ami) begin
                    par_d = ~par_q;
                end
            end else if (ami) begin
                win_d[0] = SymZero;
                zrun_d   = 3'd0;
            end else if (sub) begin
                win_d[0] = SymV;
                zrun_d   = 3'd0;
                par_d    = 1'b0;
                // Even pulse count since last V: the first zero of the run (now
                // shifting into the last slot) becomes B to keep V alternating.
                if (!par_q) begin
                    win_d[N] = SymB;
                end
            end else begin
                win_d[0] = SymZero;
                zrun_d   = zrun_q + 3'd1;
            end

            // Polarity stage on the symbol leaving the window.
            case (leave)
                SymMark, SymB: begin
                    p_d    = ~last_q;
                    n_d    = last_q;
                    last_d = ~last_q;
                end
                SymV: begin
                    p_d = last_q;
                    n_d = ~last_q;
                end
                default: begin
                    p_d = 1'b0;
                    n_d = 1'b0;
                end
            endcase

            // Suppress output until the window has been primed with N+1 beats.
            if (fill_q == FillMax) begin
                valid_d = 1'b1;
            end else begin
                fill_d = fill_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '0;
            zrun_q  <= 3'd0;
            fill_q  <= 4'd0;
            par_q   <= 1'b0;
            last_q  <= 1'b0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            zrun_q  <= zrun_d;
            fill_q  <= fill_d;
            par_q   <= par_d;
            last_q  <= last_d;
            p_q     <= p_d;
            n_q     <= n_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign data_outP = p_q;
    assign data_outN = n_q;

`ifdef HDBN_STATS_EN
    logic [15:0] viol_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            viol_q <= 16'd0;
        end else if (sub && (viol_q != 16'hFFFF)) begin
            viol_q <= viol_q + 16'd1;
        end
    end

    assign viol_cnt = viol_q;
`endif

endmodule

// File: tb/tb_hdbn_encoder.sv
// tb_hdbn_encoder: directed bench for hdbn_encoder with N = 3 and N = 2 instances
// sharing one stimulus. Expected line symbols are hand-derived HDBn sequences
// (99 = no out_valid expected for that beat).

module tb_hdbn_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic data_in = 1'b0;
    logic ami = 1'b0;

    logic ov3, p3, n3;
    logic ov2, p2, n2;
`ifdef HDBN_STATS_EN
    logic [15:0] viol3, viol2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int bits[$];
    int exps[$];
    logic held_p, held_n;

    always #5 clk = ~clk;

    hdbn_encoder #(.N(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .data_in  (data_in),
        .ami      (ami),
`ifdef HDBN_STATS_EN
        .viol_cnt (viol3),
`endif
        .out_valid(ov3),
        .data_outP(p3),
        .data_outN(n3)
    );

    hdbn_encoder #(.N(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .data_in  (data_in),
        .ami      (ami),
`ifdef HDBN_STATS_EN
        .viol_cnt (viol2),
`endif
        .out_valid(ov2),
        .data_outP(p2),
        .data_outN(n2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] observed(input int which);
        return (which == 3) ? {ov3, p3, n3} : {ov2, p2, n2};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst    = 1'b0;
        held_p = 1'b0;
        held_n = 1'b0;
    endtask

    // Plays bits[] on the chosen instance, checking {out_valid,P,N} after each beat
    // and, with gap > 0, after each idle cycle (no pulse, P/N held).
    task automatic play(input string tag, input int which, input int gap);
        logic [2:0] expv;
        for (int i = 0; i < bits.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = bits[i][0];
            @(posedge clk);
            #1;
            if (exps[i] == 99) begin
                expv = 3'b000;
            end else begin
                held_p = (exps[i] == 1);
                held_n = (exps[i] == -1);
                expv   = {1'b1, held_p, held_n};
            end
            check($sformatf("%s beat %0d", tag, i + 1), 16'(observed(which)), 16'(expv));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                data_in  = 1'b1;
                @(posedge clk);
                #1;
                check($sformatf("%s idle %0d.%0d", tag, i + 1, g), 16'(observed(which)),
                      16'({1'b0, held_p, held_n}));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        check("reset n3", 16'(observed(3)), 16'd0);
        check("reset n2", 16'(observed(2)), 16'd0);
`ifdef HDBN_STATS_EN
        check("reset viol3", viol3, 16'd0);
`endif

        // 0000 1 0000 (+ flush): B00V, mark, 000V
        bits = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        exps = '{99, 99, 99, 99, 1, 0, 0, 1, -1, 0, 0, 0, -1};
        play("b00v_000v", 3, 0);
`ifdef HDBN_STATS_EN
        check("viol3 after test1", viol3, 16'd3);
`endif

        // 1,1,0000 (+ flush ones): two marks then B00V
        do_reset();
        bits = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        exps = '{99, 99, 99, 99, 1, -1, 1, 0, 0, 1};
        play("marks_b00v", 3, 0);

        // AMI mode: no substitution
        do_reset();
        ami  = 1'b1;
        bits = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        exps = '{99, 99, 99, 99, 1, 0, 0, 0, 0, 0, -1};
        play("ami", 3, 0);
`ifdef HDBN_STATS_EN
        check("viol3 ami", viol3, 16'd0);
`endif
        ami = 1'b0;

        // N=2, six zeros: B0V B0V
        do_reset();
        bits = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        exps = '{99, 99, 99, 1, 0, 1, -1, 0, -1};
        play("n2_b0v", 2, 0);
`ifdef HDBN_STATS_EN
        check("viol2 n2", viol2, 16'd2);
`endif

        // Gapped in_valid: same stream as first test, one beat in three
        do_reset();
        bits = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        exps = '{99, 99, 99, 99, 1, 0, 0, 1, -1, 0, 0, 0, -1};
        play("gapped", 3, 2);

        // Mid-run reset after three zeros, then fresh prime and B00V
        do_reset();
        bits = '{0, 0, 0};
        exps = '{99, 99, 99};
        play("pre_rst", 3, 0);
        do_reset();
        check("mid reset", 16'(observed(3)), 16'd0);
        bits = '{0, 0, 0, 0, 0, 0, 0, 0};
        exps = '{99, 99, 99, 99, 1, 0, 0, 1};
        play("post_rst", 3, 0);
`ifdef HDBN_STATS_EN
        check("viol3 post reset", viol3, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
